// File: rtl/rvfi_compare_pkg.sv
// Shared types for the RVFI retirement comparator: buffered entry layout,
// field indices used in mismatch_fields_o, compare-state encoding and the
// per-field comparison rule.
package rvfi_compare_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_FIELDS = 6;

    localparam int FLD_ORDER    = 0;
    localparam int FLD_PC       = 1;
    localparam int FLD_INSN     = 2;
    localparam int FLD_TRAP     = 3;
    localparam int FLD_RD_ADDR  = 4;
    localparam int FLD_RD_WDATA = 5;

    typedef struct packed {
        logic [63:0]     order;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            trap;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } rvfi_cmp_entry_t;

    typedef enum logic {
        CMP_RUN    = 1'b0,
        CMP_HALTED = 1'b1
    } cmp_state_e;

    // Returns one bit per differing field. Writeback fields are meaningless
    // when both sides trapped, and rd_wdata is meaningless for x0.
    function automatic logic [NUM_FIELDS-1:0] cmp_fields(input rvfi_cmp_entry_t r,
                                                         input rvfi_cmp_entry_t d);
        logic [NUM_FIELDS-1:0] f;
        logic                  both_trap;
        logic                  both_x0;
        f         = '0;
        both_trap = r.trap && d.trap;
        both_x0   = (r.rd_addr == 5'd0) && (d.rd_addr == 5'd0);
        f[FLD_ORDER] = (r.order != d.order);
        f[FLD_PC]    = (r.pc    != d.pc);
        f[FLD_INSN]  = (r.insn  != d.insn);
        f[FLD_TRAP]  = (r.trap  != d.trap);
        if (!both_trap) begin
            f[FLD_RD_ADDR] = (r.rd_addr != d.rd_addr);
            if (!both_x0)
                f[FLD_RD_WDATA] = (r.rd_wdata != d.rd_wdata);
        end
        return f;
    endfunction

endpackage

// File: rtl/rvfi_compare_fifo.sv
// Per-stream retirement FIFO. Registered storage (no fall-through), extra
// pointer MSB distinguishes full from empty. A push into a full FIFO is
// accepted only if the head leaves in the same cycle; otherwise it is
// dropped and overflow_o pulses.
module rvfi_compare_fifo
    import rvfi_compare_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  rvfi_cmp_entry_t data_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output rvfi_cmp_entry_t head_o,
    output logic            overflow_o
);

    localparam int AW = $clog2(DEPTH);

    rvfi_cmp_entry_t mem [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic            do_push;
    logic            do_pop;

    assign empty_o    = (wptr == rptr);
    assign full_o     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign overflow_o = push_i && full_o && !do_pop;
    assign head_o     = mem[rptr[AW-1:0]];

    // Pointer update; reset discards everything buffered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Entry storage, no reset needed since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/rvfi_compare.sv
// Pairs reference-model and DUT RVFI retirements in order and compares them.
// Reports the first mismatch (sticky), per-stream overflow and a saturating
// match count. XLEN must equal rvfi_compare_pkg::XLEN.
// Optional retirement-stall watchdog: define RVFI_COMPARE_TIMEOUT_EN.
module rvfi_compare #(
    parameter int XLEN             = 32,
    parameter int DEPTH            = 8,
    parameter int STOP_ON_MISMATCH = 1,
    parameter int TIMEOUT          = 1000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ref_valid_i,
    input  logic [63:0]     ref_order_i,
    input  logic [XLEN-1:0] ref_pc_i,
    input  logic [31:0]     ref_insn_i,
    input  logic            ref_trap_i,
    input  logic [4:0]      ref_rd_addr_i,
    input  logic [XLEN-1:0] ref_rd_wdata_i,
    input  logic            dut_valid_i,
    input  logic [63:0]     dut_order_i,
    input  logic [XLEN-1:0] dut_pc_i,
    input  logic [31:0]     dut_insn_i,
    input  logic            dut_trap_i,
    input  logic [4:0]      dut_rd_addr_i,
    input  logic [XLEN-1:0] dut_rd_wdata_i,
    output logic            mismatch_o,
    output logic [5:0]      mismatch_fields_o,
    output logic [63:0]     mismatch_order_o,
    output logic [1:0]      overflow_o,
    output logic [31:0]     match_count_o,
    output logic            halted_o,
    output logic            timeout_o
);

    import rvfi_compare_pkg::*;

    rvfi_cmp_entry_t       ref_in, dut_in, ref_head, dut_head;
    logic                  ref_full, ref_empty, ref_ovf;
    logic                  dut_full, dut_empty, dut_ovf;
    logic                  pop;
    logic [NUM_FIELDS-1:0] diff;
    cmp_state_e            state;

    assign ref_in = '{order: ref_order_i, pc: ref_pc_i, insn: ref_insn_i, trap: ref_trap_i,
                      rd_addr: ref_rd_addr_i, rd_wdata: ref_rd_wdata_i};
    assign dut_in = '{order: dut_order_i, pc: dut_pc_i, insn: dut_insn_i, trap: dut_trap_i,
                      rd_addr: dut_rd_addr_i, rd_wdata: dut_rd_wdata_i};

    rvfi_compare_fifo #(.DEPTH(DEPTH)) u_ref_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(ref_valid_i), .data_i(ref_in),
        .pop_i(pop), .full_o(ref_full), .empty_o(ref_empty), .head_o(ref_head),
        .overflow_o(ref_ovf)
    );

    rvfi_compare_fifo #(.DEPTH(DEPTH)) u_dut_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(dut_valid_i), .data_i(dut_in),
        .pop_i(pop), .full_o(dut_full), .empty_o(dut_empty), .head_o(dut_head),
        .overflow_o(dut_ovf)
    );

    // Both heads leave together; nothing moves while halted.
    assign pop      = (state == CMP_RUN) && !ref_empty && !dut_empty;
    assign diff     = cmp_fields(ref_head, dut_head);
    assign halted_o = (state == CMP_HALTED);

    // Registered compare result: match counting, first-mismatch capture, halt.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state             <= CMP_RUN;
            mismatch_o        <= 1'b0;
            mismatch_fields_o <= '0;
            mismatch_order_o  <= '0;
            match_count_o     <= '0;
        end else if (pop) begin
            if (diff == '0) begin
                if (match_count_o != '1) match_count_o <= match_count_o + 1'b1;
            end else if (!mismatch_o) begin
                mismatch_o        <= 1'b1;
                mismatch_fields_o <= diff;
                mismatch_order_o  <= dut_head.order;
                if (STOP_ON_MISMATCH != 0) state <= CMP_HALTED;
            end
        end
    end

    // Sticky per-stream overflow flags; full flags are informational only.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) overflow_o <= 2'b00;
        else         overflow_o <= overflow_o | {dut_ovf && !dut_full ? 1'b0 : dut_ovf,
                                                 ref_ovf && !ref_full ? 1'b0 : ref_ovf};
    end

`ifdef RVFI_COMPARE_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Counts cycles where one stream is ahead and the other has nothing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt    <= '0;
            timeout_o <= 1'b0;
        end else if (state == CMP_RUN) begin
            if (pop || (ref_empty && dut_empty)) begin
                to_cnt <= '0;
            end else if ((ref_empty != dut_empty) && (to_cnt != 32'(TIMEOUT))) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt + 32'd1 == 32'(TIMEOUT)) timeout_o <= 1'b1;
            end
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_compare.sv
// Directed bench for rvfi_compare: queue-based reference model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_rvfi_compare;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ref_valid, dut_valid;
    logic [63:0] ref_order, dut_order;
    logic [31:0] ref_pc, dut_pc, ref_insn, dut_insn, ref_wd, dut_wd;
    logic        ref_trap, dut_trap;
    logic [4:0]  ref_rd, dut_rd;
    logic        mismatch_o, halted_o, timeout_o;
    logic [5:0]  mismatch_fields_o;
    logic [63:0] mismatch_order_o;
    logic [1:0]  overflow_o;
    logic [31:0] match_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvfi_compare #(.XLEN(32), .DEPTH(DEPTH), .STOP_ON_MISMATCH(1), .TIMEOUT(1000)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ref_valid_i(ref_valid), .ref_order_i(ref_order), .ref_pc_i(ref_pc),
        .ref_insn_i(ref_insn), .ref_trap_i(ref_trap), .ref_rd_addr_i(ref_rd),
        .ref_rd_wdata_i(ref_wd),
        .dut_valid_i(dut_valid), .dut_order_i(dut_order), .dut_pc_i(dut_pc),
        .dut_insn_i(dut_insn), .dut_trap_i(dut_trap), .dut_rd_addr_i(dut_rd),
        .dut_rd_wdata_i(dut_wd),
        .mismatch_o(mismatch_o), .mismatch_fields_o(mismatch_fields_o),
        .mismatch_order_o(mismatch_order_o), .overflow_o(overflow_o),
        .match_count_o(match_count_o), .halted_o(halted_o), .timeout_o(timeout_o)
    );

    // ---------------- behavioural model ----------------
    ent_t        rq[$];
    ent_t        dq[$];
    logic        m_mis = 1'b0, m_halt = 1'b0;
    logic [5:0]  m_f = '0;
    logic [63:0] m_ord = '0;
    logic [1:0]  m_ovf = '0;
    logic [31:0] m_cnt = '0;

    function automatic logic [5:0] field_diff(input ent_t r, input ent_t d);
        logic [5:0] f = '0;
        f[0] = r.order != d.order;
        f[1] = r.pc != d.pc;
        f[2] = r.insn != d.insn;
        f[3] = r.trap != d.trap;
        if (!(r.trap && d.trap)) begin
            f[4] = r.rd != d.rd;
            if (!(r.rd == 0 && d.rd == 0)) f[5] = r.wd != d.wd;
        end
        return f;
    endfunction

    always @(posedge clk) begin
        ent_t       r, d;
        logic       popped;
        logic [5:0] f;
        if (!rst_n) begin
            rq.delete(); dq.delete();
            m_mis = 0; m_halt = 0; m_f = 0; m_ord = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            popped = 0;
            if (!m_halt && rq.size() > 0 && dq.size() > 0) begin
                r = rq.pop_front();
                d = dq.pop_front();
                popped = 1;
                f = field_diff(r, d);
                if (f == 0) begin
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end else if (!m_mis) begin
                    m_mis = 1; m_f = f; m_ord = d.order; m_halt = 1;
                end
            end
            if (ref_valid) begin
                if (rq.size() < DEPTH || popped)
                    rq.push_back('{ref_order, ref_pc, ref_insn, ref_trap, ref_rd, ref_wd});
                else m_ovf[0] = 1;
            end
            if (dut_valid) begin
                if (dq.size() < DEPTH || popped)
                    dq.push_back('{dut_order, dut_pc, dut_insn, dut_trap, dut_rd, dut_wd});
                else m_ovf[1] = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        checks++;
        if ({mismatch_o, mismatch_fields_o, mismatch_order_o, overflow_o, match_count_o,
             halted_o, timeout_o} !==
            {m_mis, m_f, m_ord, m_ovf, m_cnt, m_halt, 1'b0}) begin
            errors++;
            $display("FAIL model_cmp t=%0t got mis=%b f=%b ord=%0d ovf=%b cnt=%0d halt=%b to=%b want mis=%b f=%b ord=%0d ovf=%b cnt=%0d halt=%b to=0",
                     $time, mismatch_o, mismatch_fields_o, mismatch_order_o, overflow_o,
                     match_count_o, halted_o, timeout_o, m_mis, m_f, m_ord, m_ovf, m_cnt, m_halt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input int k);
        ent_t e;
        e.order = 64'(k);
        e.pc    = 32'h8000_0000 + 32'(4 * k);
        e.insn  = 32'h0000_0013 | (32'(k) << 20);
        e.trap  = 1'b0;
        e.rd    = 5'd5;
        e.wd    = 32'(k * 3 + 1);
        return e;
    endfunction

    task automatic push(input logic rv, input logic dv, input ent_t r, input ent_t d);
        ref_valid = rv; ref_order = r.order; ref_pc = r.pc; ref_insn = r.insn;
        ref_trap = r.trap; ref_rd = r.rd; ref_wd = r.wd;
        dut_valid = dv; dut_order = d.order; dut_pc = d.pc; dut_insn = d.insn;
        dut_trap = d.trap; dut_rd = d.rd; dut_wd = d.wd;
        @(posedge clk); #1;
        ref_valid = 0; dut_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        ent_t a, b;
        rst_n = 0;
        push(0, 0, mk(0), mk(0));
        idle(1);
        chk("rst_mismatch", 64'(mismatch_o), 0);
        chk("rst_match", 64'(match_count_o), 0);
        chk("rst_halted", 64'(halted_o), 0);
        chk("rst_overflow", 64'(overflow_o), 0);
        rst_n = 1;

        // Identical lock-step retirements.
        for (int k = 0; k < 5; k++) push(1, 1, mk(k), mk(k));
        idle(3);
        chk("t1_match", 64'(match_count_o), 5);
        chk("t1_mismatch", 64'(mismatch_o), 0);

        // DUT lags reference by several cycles.
        do_reset();
        for (int k = 0; k < 4; k++) push(1, 0, mk(k), mk(0));
        idle(5);
        for (int k = 0; k < 4; k++) push(0, 1, mk(0), mk(k));
        idle(3);
        chk("t2_match", 64'(match_count_o), 4);
        chk("t2_overflow", 64'(overflow_o), 0);
        chk("t2_timeout", 64'(timeout_o), 0);

        // rd_wdata mismatch at order 2; mismatch_o two cycles after push.
        do_reset();
        push(1, 1, mk(0), mk(0));
        push(1, 1, mk(1), mk(1));
        a = mk(2); b = a; a.wd = 32'h2; b.wd = 32'h1;
        push(1, 1, a, b);
        chk("t3_latency_early", 64'(mismatch_o), 0);
        push(1, 1, mk(3), mk(3));
        chk("t3_latency", 64'(mismatch_o), 1);
        idle(2);
        chk("t3_fields", 64'(mismatch_fields_o), 64'b100000);
        chk("t3_order", mismatch_order_o, 2);
        chk("t3_halted", 64'(halted_o), 1);
        chk("t3_match", 64'(match_count_o), 2);
        // Halted: DUT FIFO already holds order 3, fills after 7 more, 8th drops.
        for (int k = 4; k < 12; k++) push(0, 1, mk(0), mk(k));
        chk("t3_halt_ovf", 64'(overflow_o), 64'b10);
        chk("t3_halt_cnt", 64'(match_count_o), 2);

        // x0 writeback and both-trap cases count as matches; trap-only difference.
        do_reset();
        a = mk(0); a.rd = 0; a.wd = 32'hDEAD; b = a; b.wd = 32'hBEEF;
        push(1, 1, a, b);
        a = mk(1); a.trap = 1; b = a; b.wd = 32'h5; b.rd = 5'd7;
        push(1, 1, a, b);
        idle(2);
        chk("t4_match", 64'(match_count_o), 2);
        chk("t4_mismatch", 64'(mismatch_o), 0);
        a = mk(2); b = a; b.trap = 1;
        push(1, 1, a, b);
        idle(2);
        chk("t4_trap_fields", 64'(mismatch_fields_o), 64'b001000);
        chk("t4_trap_order", mismatch_order_o, 2);

        // DUT overflow with no reference traffic; 9th entry must be gone.
        do_reset();
        for (int k = 0; k < 9; k++) push(0, 1, mk(0), mk(k));
        chk("t5_overflow", 64'(overflow_o), 64'b10);
        for (int k = 0; k < 8; k++) push(1, 0, mk(k), mk(0));
        idle(2);
        chk("t5_match", 64'(match_count_o), 8);
        push(1, 0, mk(8), mk(0));
        idle(3);
        chk("t5_dropped", 64'(match_count_o), 8);
        chk("t5_nomis", 64'(mismatch_o), 0);

        // Mid-stream reset while halted with buffered reference entries.
        do_reset();
        a = mk(0); b = a; b.pc = 32'h1234;
        push(1, 1, a, b);
        for (int k = 1; k < 4; k++) push(1, 0, mk(k), mk(0));
        chk("t6_halted", 64'(halted_o), 1);
        do_reset();
        chk("t6_rst_mis", 64'(mismatch_o), 0);
        chk("t6_rst_halt", 64'(halted_o), 0);
        chk("t6_rst_fields", 64'(mismatch_fields_o), 0);
        chk("t6_rst_order", mismatch_order_o, 0);
        push(0, 1, mk(0), mk(5));
        idle(3);
        chk("t6_empty_mis", 64'(mismatch_o), 0);
        chk("t6_empty_cnt", 64'(match_count_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
